// File: rtl/icb_sram_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icb_sram_slave
//
// ICB responder in front of a word-addressed on-chip buffer. Every accepted
// command (read or byte-masked write) produces exactly one response, returned
// strictly in command order through a small response FIFO. cmd_ready drops as
// soon as every response slot is committed, which throttles the master when
// the response channel is backpressured.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset (FIFO state only; the array
//                  keeps its contents)
//   icb_cmd_valid  command valid from master
//   icb_cmd_ready  slave can take a command (count < RSP_DEPTH)
//   icb_cmd_addr   byte address
//   icb_cmd_read   1 = read, 0 = write
//   icb_cmd_wdata  write data
//   icb_cmd_wmask  byte enables, bit i covers wdata[8i+7:8i]
//   icb_rsp_valid  response valid (FIFO not empty)
//   icb_rsp_ready  master takes the response
//   icb_rsp_rdata  read data, 0 for writes and errors
//   icb_rsp_err    out-of-range or misaligned command
// -----------------------------------------------------------------------------
module icb_sram_slave #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h4000_0000,
    parameter int              RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [DW-1:0] icb_cmd_wdata,
    input  logic [3:0]    icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic [DW-1:0] icb_rsp_rdata,
    output logic          icb_rsp_err
);

    localparam int NL = 4;                        // byte lanes of the 32-bit word
    localparam int IW = $clog2(DEPTH);            // array index width
    localparam int PW = $clog2(RSP_DEPTH);        // FIFO pointer width
    localparam int CW = $clog2(RSP_DEPTH + 1);    // FIFO occupancy width (0..RSP_DEPTH)

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [AW-1:0] word_off;
    logic          addr_hit;
    logic [IW-1:0] idx;
    logic          cmd_hs;
    logic          rsp_hs;
    logic          wr_en;
    logic          rd_en;

    logic [DW-1:0]        head_rdata;
    logic [RSP_DEPTH-1:0] fifo_err_reg;

    // ------------------------------------------------------------------
    // Handshakes and address decode
    // ------------------------------------------------------------------
    assign icb_cmd_ready = (count_reg < CW'(RSP_DEPTH));
    assign icb_rsp_valid = (count_reg != '0);

    assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs = icb_rsp_valid & icb_rsp_ready;

    // Word offset from the window base; the >= test below rejects addresses
    // under the base whose subtraction wrapped around.
    assign word_off = (icb_cmd_addr - BASE_ADDR) >> 2;
    assign addr_hit = (icb_cmd_addr >= BASE_ADDR) &&
                      (word_off < AW'(DEPTH)) &&
                      (icb_cmd_addr[1:0] == 2'b00);
    assign idx      = word_off[IW-1:0];

    assign wr_en = cmd_hs & addr_hit & ~icb_cmd_read;
    assign rd_en = cmd_hs & addr_hit &  icb_cmd_read;

    // ------------------------------------------------------------------
    // Storage, split per byte lane so each lane is a plain single-port
    // array with a byte write enable. The read result lands directly in
    // the response FIFO slot being pushed, so the response is available
    // the cycle after acceptance with no combinational cmd->rsp path.
    // Writes and errors push zero data.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            logic [7:0] lane_mem  [DEPTH];
            logic [7:0] lane_fifo [RSP_DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && icb_cmd_wmask[gi]) begin
                    lane_mem[idx] <= icb_cmd_wdata[8*gi +: 8];
                end
                if (cmd_hs) begin
                    lane_fifo[wr_ptr_reg] <= rd_en ? lane_mem[idx] : 8'h00;
                end
            end

            assign head_rdata[8*gi +: 8] = lane_fifo[rd_ptr_reg];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            fifo_err_reg[wr_ptr_reg] <= ~addr_hit;
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping. Pointers wrap naturally (RSP_DEPTH is a power of
    // two). Push and pop in the same cycle leave the count unchanged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (cmd_hs) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (rsp_hs) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({cmd_hs, rsp_hs})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The payload slots are not reset, so the outputs are forced to zero
    // whenever no response is pending; this also gives the zero reset value.
    assign icb_rsp_rdata = icb_rsp_valid ? head_rdata : '0;
    assign icb_rsp_err   = icb_rsp_valid & fifo_err_reg[rd_ptr_reg];

endmodule
